// File: rtl/ps2_mouse_device.sv
// Device-side PS/2 mouse: generates the PS/2 clock, answers host commands and streams 3-byte packets.
// Optional macro PS2_MOUSE_SYNC_EN adds 2-flop synchronizers on ps2c_in/ps2d_in.
module ps2_mouse_device #(
  parameter int CLK_DIV = 1250
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps2c_in,
  input  logic              ps2d_in,
  output logic              ps2c_oe,
  output logic              ps2d_oe,
  input  logic              mv_valid,
  output logic              mv_ready,
  input  logic signed [8:0] mv_dx,
  input  logic signed [8:0] mv_dy,
  input  logic        [2:0] mv_btn,
  output logic              streaming,
  output logic              cmd_valid,
  output logic        [7:0] cmd_byte,
  output logic              rx_err
);

  typedef enum logic [2:0] {IDLE, TX_BIT, TX_GAP, RX_RTS, RX_BIT, RX_ACK} state_t;

  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_M1 = 16'(2 * CLK_DIV - 1);

  function automatic logic [10:0] tx_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  function automatic logic [7:0] pkt_head(input logic [8:0] dx, input logic [8:0] dy,
                                          input logic [2:0] btn);
    return {2'b00, dy[8], dx[8], 1'b1, btn};
  endfunction

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [3:0]  r_bit;
  logic        r_phase;
  logic [10:0] r_frame;
  logic [9:0]  r_rx;
  logic [7:0]  r_q [3];
  logic [1:0]  r_qcnt;
  logic        r_clow;
  logic        r_c_oe;
  logic        r_d_oe;
  logic        r_stream;
  logic        r_cmd_valid;
  logic [7:0]  r_cmd_byte;
  logic        r_rx_err;

  logic w_c;
  logic w_d;
  logic w_cok;
  logic w_rts;
  logic w_hs;
  logic w_rx_good;

`ifdef PS2_MOUSE_SYNC_EN
  logic [1:0] r_c_sync;
  logic [1:0] r_d_sync;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_c_sync <= 2'b11;
      r_d_sync <= 2'b11;
    end else begin
      r_c_sync <= {r_c_sync[0], ps2c_in};
      r_d_sync <= {r_d_sync[0], ps2d_in};
    end
  end
  assign w_c   = r_c_sync[1];
  assign w_d   = r_d_sync[1];
  // Our own clock release needs two cycles to show up through the synchronizer.
  assign w_cok = (r_cnt > 16'd1);
`else
  assign w_c   = ps2c_in;
  assign w_d   = ps2d_in;
  assign w_cok = 1'b1;
`endif

  assign w_rts     = r_clow & w_c & ~w_d;
  assign w_rx_good = (^r_rx[8:0]) & r_rx[9];
  assign mv_ready  = r_stream & (r_state == IDLE) & (r_qcnt == 2'd0) & w_c;
  assign w_hs      = mv_valid & mv_ready;

  assign ps2c_oe   = r_c_oe;
  assign ps2d_oe   = r_d_oe;
  assign streaming = r_stream;
  assign cmd_valid = r_cmd_valid;
  assign cmd_byte  = r_cmd_byte;
  assign rx_err    = r_rx_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 16'd0;
      r_bit       <= 4'd0;
      r_phase     <= 1'b0;
      r_qcnt      <= 2'd0;
      r_clow      <= 1'b0;
      r_c_oe      <= 1'b0;
      r_d_oe      <= 1'b0;
      r_stream    <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd_byte  <= 8'd0;
      r_rx_err    <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_rx_err    <= 1'b0;
      // Remember a host-driven clock low; our own pulls do not count.
      if (!w_c && !r_c_oe) r_clow <= 1'b1;
      else if (w_c)        r_clow <= 1'b0;

      case (r_state)
        IDLE: begin
          r_c_oe  <= 1'b0;
          r_d_oe  <= 1'b0;
          r_cnt   <= 16'd0;
          r_bit   <= 4'd0;
          r_phase <= 1'b0;
          if (w_hs) begin
            r_q[0] <= pkt_head(mv_dx, mv_dy, mv_btn);
            r_q[1] <= mv_dx[7:0];
            r_q[2] <= mv_dy[7:0];
            r_qcnt <= 2'd3;
          end
          if (w_rts) begin
            r_state <= RX_RTS;
          end else if ((r_qcnt != 2'd0) && w_c) begin
            r_frame <= tx_frame(r_q[0]);
            r_d_oe  <= 1'b1;
            r_state <= TX_BIT;
          end
        end

        TX_BIT: begin
          r_cnt <= r_cnt + 16'd1;
          if (!r_phase) begin
            if (!w_c && w_cok) begin
              r_c_oe  <= 1'b0;
              r_d_oe  <= 1'b0;
              r_state <= IDLE;
            end else if (r_cnt == DIV_M1) begin
              r_cnt   <= 16'd0;
              r_phase <= 1'b1;
              r_c_oe  <= 1'b1;
            end
          end else if (r_cnt == DIV_M1) begin
            r_cnt   <= 16'd0;
            r_phase <= 1'b0;
            r_c_oe  <= 1'b0;
            if (r_bit == 4'd10) begin
              r_d_oe  <= 1'b0;
              r_state <= TX_GAP;
            end else begin
              r_bit   <= r_bit + 4'd1;
              r_frame <= r_frame >> 1;
              r_d_oe  <= ~r_frame[1];
            end
          end
        end

        TX_GAP: begin
          r_cnt <= r_cnt + 16'd1;
          if (w_rts) begin
            r_cnt   <= 16'd0;
            r_state <= RX_RTS;
          end else if (r_cnt == GAP_M1) begin
            r_q[0]  <= r_q[1];
            r_q[1]  <= r_q[2];
            r_qcnt  <= r_qcnt - 2'd1;
            r_state <= IDLE;
          end
        end

        RX_RTS: begin
          r_cnt <= r_cnt + 16'd1;
          if (r_cnt == DIV_M1) begin
            r_cnt   <= 16'd0;
            r_c_oe  <= 1'b1;
            r_phase <= 1'b1;
            r_bit   <= 4'd0;
            r_state <= RX_BIT;
          end
        end

        RX_BIT: begin
          r_cnt <= r_cnt + 16'd1;
          if (r_cnt == DIV_M1) begin
            r_cnt <= 16'd0;
            if (r_phase) begin
              r_c_oe  <= 1'b0;
              r_phase <= 1'b0;
              r_rx    <= {w_d, r_rx[9:1]};
            end else begin
              r_c_oe  <= 1'b1;
              r_phase <= 1'b1;
              if (r_bit == 4'd9) begin
                r_d_oe  <= 1'b1;
                r_state <= RX_ACK;
              end else begin
                r_bit <= r_bit + 4'd1;
              end
            end
          end
        end

        RX_ACK: begin
          r_cnt <= r_cnt + 16'd1;
          if (r_cnt == DIV_M1) begin
            r_cnt <= 16'd0;
            if (r_phase) begin
              r_c_oe  <= 1'b0;
              r_d_oe  <= 1'b0;
              r_phase <= 1'b0;
            end else begin
              r_state <= IDLE;
              // Any pending reply or packet is replaced by the answer to this byte.
              if (w_rx_good) begin
                r_cmd_valid <= 1'b1;
                r_cmd_byte  <= r_rx[7:0];
                r_q[0]      <= 8'hFA;
                r_qcnt      <= 2'd1;
                case (r_rx[7:0])
                  8'hFF: begin
                    r_q[1]   <= 8'hAA;
                    r_q[2]   <= 8'h00;
                    r_qcnt   <= 2'd3;
                    r_stream <= 1'b0;
                  end
                  8'hF4:        r_stream <= 1'b1;
                  8'hF5, 8'hF6: r_stream <= 1'b0;
                  default: ;
                endcase
              end else begin
                r_rx_err <= 1'b1;
                r_q[0]   <= 8'hFE;
                r_qcnt   <= 2'd1;
              end
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_mouse_device.sv
// Bench for ps2_mouse_device: a host model on an open-drain bus, a command table and packet/abort/reset sequences.
module tb_ps2_mouse_device;
  localparam int DIV = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              h_c = 1'b0;
  logic              h_d = 1'b0;
  logic              ps2c_in;
  logic              ps2d_in;
  logic              ps2c_oe;
  logic              ps2d_oe;
  logic              mv_valid = 1'b0;
  logic              mv_ready;
  logic signed [8:0] mv_dx = 9'sd0;
  logic signed [8:0] mv_dy = 9'sd0;
  logic        [2:0] mv_btn = 3'd0;
  logic              streaming;
  logic              cmd_valid;
  logic        [7:0] cmd_byte;
  logic              rx_err;

  always #5 clk = ~clk;

  assign ps2c_in = ~(ps2c_oe | h_c);
  assign ps2d_in = ~(ps2d_oe | h_d);

  ps2_mouse_device #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .ps2c_in(ps2c_in), .ps2d_in(ps2d_in),
    .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe), .mv_valid(mv_valid), .mv_ready(mv_ready),
    .mv_dx(mv_dx), .mv_dy(mv_dy), .mv_btn(mv_btn), .streaming(streaming),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .rx_err(rx_err)
  );

  int         total = 0;
  int         bad = 0;
  int         cv_cnt = 0;
  int         err_cnt = 0;
  int         rdy_cnt = 0;
  logic [7:0] cb = 8'd0;
  logic       watch = 1'b0;

  always @(negedge clk) begin
    if (cmd_valid) begin
      cv_cnt++;
      cb = cmd_byte;
    end
    if (rx_err) err_cnt++;
    if (watch && mv_ready) rdy_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_c(input logic lvl, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ps2c_oe == lvl) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s: ps2c_oe never reached %0d", nm, lvl);
    end
  endtask

  task automatic host_send(input logic [7:0] b, input logic badpar, output logic acked);
    logic [9:0] bits;
    bits = {1'b1, (badpar ? ^b : ~^b), b};
    @(negedge clk);
    h_c = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    h_d = 1'b1;
    @(negedge clk);
    h_c = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wait_c(1'b1, "rx_pulse");
      h_d = ~bits[i];
      wait_c(1'b0, "rx_release");
    end
    wait_c(1'b1, "ack_pulse");
    acked = ps2d_oe;
    wait_c(1'b0, "ack_release");
  endtask

  task automatic host_recv(output logic [7:0] b, output logic ok);
    logic [10:0] f;
    for (int i = 0; i < 11; i++) begin
      wait_c(1'b1, "tx_fall");
      f[i] = ps2d_in;
      wait_c(1'b0, "tx_rise");
    end
    b  = f[8:1];
    ok = (f[0] == 1'b0) && (f[10] == 1'b1) && ((^f[9:1]) == 1'b1);
  endtask

  typedef struct packed {
    logic [7:0]  cmd;
    logic        badpar;
    logic [1:0]  nrep;
    logic [23:0] rep;
    logic        strm;
    logic        cv;
    logic        err;
  } vec_t;

  initial begin
    vec_t        vt[8];
    logic [7:0]  rb;
    logic        ok;
    logic        ack;
    logic [23:0] rep;
    logic [7:0]  pk[3];
    int          cv0;
    int          er0;
    int          r0;
    int          n1;
    int          n2;
    int          first;

    vt[0] = '{8'hFF, 1'b0, 2'd3, 24'hFAAA00, 1'b0, 1'b1, 1'b0};
    vt[1] = '{8'hF4, 1'b0, 2'd1, 24'hFA0000, 1'b1, 1'b1, 1'b0};
    vt[2] = '{8'h55, 1'b0, 2'd1, 24'hFA0000, 1'b1, 1'b1, 1'b0};
    vt[3] = '{8'hA5, 1'b1, 2'd1, 24'hFE0000, 1'b1, 1'b0, 1'b1};
    vt[4] = '{8'hF5, 1'b0, 2'd1, 24'hFA0000, 1'b0, 1'b1, 1'b0};
    vt[5] = '{8'hF6, 1'b0, 2'd1, 24'hFA0000, 1'b0, 1'b1, 1'b0};
    vt[6] = '{8'hA5, 1'b1, 2'd1, 24'hFE0000, 1'b0, 1'b0, 1'b1};
    vt[7] = '{8'hF4, 1'b0, 2'd1, 24'hFA0000, 1'b1, 1'b1, 1'b0};
    pk[0] = 8'h19;
    pk[1] = 8'hFB;
    pk[2] = 8'h03;

    repeat (3) @(negedge clk);
    chk("rst_c_oe", 32'(ps2c_oe), 32'd0);
    chk("rst_d_oe", 32'(ps2d_oe), 32'd0);
    chk("rst_streaming", 32'(streaming), 32'd0);
    chk("rst_mv_ready", 32'(mv_ready), 32'd0);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_rx_err", 32'(rx_err), 32'd0);
    chk("rst_cmd_byte", 32'(cmd_byte), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      cv0 = cv_cnt;
      er0 = err_cnt;
      host_send(vt[v].cmd, vt[v].badpar, ack);
      chk($sformatf("ack_v%0d", v), 32'(ack), 32'd1);
      rep = vt[v].rep;
      for (int j = 0; j < 32'(vt[v].nrep); j++) begin
        host_recv(rb, ok);
        chk($sformatf("reply_v%0d_b%0d", v, j), 32'(rb), 32'(rep[23 - 8 * j -: 8]));
        chk($sformatf("frame_v%0d_b%0d", v, j), 32'(ok), 32'd1);
      end
      repeat (3 * DIV + 2) @(negedge clk);
      chk($sformatf("stream_v%0d", v), 32'(streaming), 32'(vt[v].strm));
      chk($sformatf("cmd_valid_v%0d", v), 32'(cv_cnt - cv0), 32'(vt[v].cv));
      chk($sformatf("rx_err_v%0d", v), 32'(err_cnt - er0), 32'(vt[v].err));
      if (vt[v].cv) chk($sformatf("cmd_byte_v%0d", v), 32'(cb), 32'(vt[v].cmd));
    end

    // Movement packet after F4
    chk("rdy_idle", 32'(mv_ready), 32'd1);
    mv_dx = 9'h1FB;
    mv_dy = 9'h003;
    mv_btn = 3'b001;
    mv_valid = 1'b1;
    @(negedge clk);
    mv_valid = 1'b0;
    chk("rdy_after_hs", 32'(mv_ready), 32'd0);
    r0 = rdy_cnt;
    watch = 1'b1;
    for (int j = 0; j < 3; j++) begin
      host_recv(rb, ok);
      chk($sformatf("pkt_b%0d", j), 32'(rb), 32'(pk[j]));
      chk($sformatf("pkt_frame_b%0d", j), 32'(ok), 32'd1);
    end
    watch = 1'b0;
    chk("rdy_during_pkt", 32'(rdy_cnt - r0), 32'd0);
    first = -1;
    for (int i = 0; i < 4 * DIV; i++) begin
      @(negedge clk);
      if (mv_ready) begin
        first = i;
        break;
      end
    end
    chk("rdy_after_gap", 32'((first >= 2 * DIV - 2) && (first <= 2 * DIV + 1)), 32'd1);

    // Host inhibit in the 4th bit of FB, then full retransmission
    mv_valid = 1'b1;
    @(negedge clk);
    mv_valid = 1'b0;
    host_recv(rb, ok);
    chk("abort_pkt_b0", 32'(rb), 32'h19);
    for (int k = 0; k < 3; k++) begin
      wait_c(1'b1, "abort_fall");
      wait_c(1'b0, "abort_rise");
    end
    chk("abort_d_before", 32'(ps2d_oe), 32'd1);
    h_c = 1'b1;
    @(negedge clk);
    chk("abort_c_released", 32'(ps2c_oe), 32'd0);
    chk("abort_d_released", 32'(ps2d_oe), 32'd0);
    n1 = 0;
    repeat (20) begin
      @(negedge clk);
      if (ps2c_oe || ps2d_oe) n1++;
    end
    chk("inhibit_quiet", 32'(n1), 32'd0);
    h_c = 1'b0;
    host_recv(rb, ok);
    chk("resend_fb", 32'(rb), 32'hFB);
    chk("resend_fb_frame", 32'(ok), 32'd1);
    host_recv(rb, ok);
    chk("resend_03", 32'(rb), 32'h03);
    repeat (3 * DIV) @(negedge clk);

    // Streaming off: offered samples are ignored
    host_send(8'hF5, 1'b0, ack);
    chk("ack_f5", 32'(ack), 32'd1);
    host_recv(rb, ok);
    chk("f5_reply", 32'(rb), 32'hFA);
    repeat (3 * DIV) @(negedge clk);
    chk("f5_stream", 32'(streaming), 32'd0);
    mv_valid = 1'b1;
    n1 = 0;
    n2 = 0;
    repeat (10000) begin
      @(negedge clk);
      if (mv_ready) n1++;
      if (ps2c_oe) n2++;
    end
    mv_valid = 1'b0;
    chk("idle_no_ready", 32'(n1), 32'd0);
    chk("idle_no_clock", 32'(n2), 32'd0);

    // Reset in the middle of the FA reply
    host_send(8'hF4, 1'b0, ack);
    chk("ack_f4_rst", 32'(ack), 32'd1);
    wait_c(1'b1, "fa_start");
    chk("fa_start_low", 32'(ps2d_oe), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_c", 32'(ps2c_oe), 32'd0);
    chk("rst_mid_d", 32'(ps2d_oe), 32'd0);
    chk("rst_mid_stream", 32'(streaming), 32'd0);
    chk("rst_mid_cmd_byte", 32'(cmd_byte), 32'd0);
    rst = 1'b0;
    n1 = 0;
    repeat (300) begin
      @(negedge clk);
      if (ps2c_oe || ps2d_oe) n1++;
    end
    chk("rst_no_frames", 32'(n1), 32'd0);
    chk("rst_no_ready", 32'(mv_ready), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
